// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: arbiter states, sizing helper
// and bus-wide constants.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int ADDR_WIDTH           = 12;
    localparam int DATA_WIDTH           = 8;
    localparam int SLAVE_MEM_ADDR_WIDTH = 12;

    // ceil(log2(n)) with a floor of 1 so a select bus always has at least one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping,
// with 'last' itself lowest priority.
module rr_priority_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [SEL_W-1:0]       last,
    output logic                   valid,
    output logic [SEL_W-1:0]       idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit is the one kept.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = SEL_W'((int'(last) + k) % NUM_MASTERS);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter holding ownership for a whole transaction, with a
// turnaround cycle between grants and an optional hold-time watchdog.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int SEL_W          = clog2(NUM_MASTERS),
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [SEL_W-1:0]       msel,
    output logic                   bbusy,
    output logic                   timeout_evt
);

    localparam bit               WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_MASTERS - 1);

    arb_state_t             state, state_nx;
    logic [NUM_MASTERS-1:0] mask, mask_nx, eff_req, bgrant_nx;
    logic [SEL_W-1:0]       last_owner, last_nx, msel_nx, win_idx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   win_vld, bbusy_nx, tevt_nx;

    assign eff_req = breq & ~mask;

    rr_priority_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .SEL_W      (SEL_W)
    ) u_pick (
        .req  (eff_req),
        .last (last_owner),
        .valid(win_vld),
        .idx  (win_idx)
    );

    always_comb begin
        state_nx  = state;
        bgrant_nx = '0;
        msel_nx   = msel;
        bbusy_nx  = 1'b0;
        tevt_nx   = 1'b0;
        cnt_nx    = cnt;
        last_nx   = last_owner;
        // a master that lets go of breq is forgiven its timeout
        mask_nx   = mask & breq;
        case (state)
            IDLE, RELEASE: begin
                if (win_vld) begin
                    state_nx  = GRANT;
                    bgrant_nx = NUM_MASTERS'(1) << win_idx;
                    msel_nx   = win_idx;
                    bbusy_nx  = 1'b1;
                    cnt_nx    = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                cnt_nx = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
                if (!breq[msel]) begin
                    state_nx = RELEASE;
                    last_nx  = msel;
                end else if (WD_EN && (cnt == TO_LAST)) begin
                    state_nx      = RELEASE;
                    tevt_nx       = 1'b1;
                    mask_nx[msel] = 1'b1;
                    last_nx       = msel;
                end else begin
                    bgrant_nx = bgrant;
                    bbusy_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bgrant      <= '0;
            msel        <= '0;
            bbusy       <= 1'b0;
            timeout_evt <= 1'b0;
            cnt         <= '0;
            mask        <= '0;
            last_owner  <= LAST_RST;
        end else begin
            state       <= state_nx;
            bgrant      <= bgrant_nx;
            msel        <= msel_nx;
            bbusy       <= bbusy_nx;
            timeout_evt <= tevt_nx;
            cnt         <= cnt_nx;
            mask        <= mask_nx;
            last_owner  <= last_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: cycle vector table plus multi-cycle
// sequences for alternation, watchdog and asynchronous reset.
module tb_bus_arbiter_rr;

    logic       clk, rstn;
    logic [1:0] breq;
    logic [1:0] g0, g1;
    logic       m0, m1, busy0, busy1, te0, te1;
    int         total = 0;
    int         bad   = 0;

    bus_arbiter_rr #(.NUM_MASTERS(2), .SEL_W(1), .TIMEOUT_CYCLES(0), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .breq(breq), .bgrant(g0), .msel(m0),
        .bbusy(busy0), .timeout_evt(te0));

    bus_arbiter_rr #(.NUM_MASTERS(2), .SEL_W(1), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut_wd (
        .clk(clk), .rstn(rstn), .breq(breq), .bgrant(g1), .msel(m1),
        .bbusy(busy1), .timeout_evt(te1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] breq;
        logic [1:0] g;
        logic       busy;
        logic       msel;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("inv_onehot0", int'($onehot0(g0)), 1);
        chk("inv_busy",    int'(g0 != 2'b00), int'(busy0));
        chk("inv_onehot1", int'($onehot0(g1)), 1);
        chk("inv_busy_wd", int'(g1 != 2'b00), int'(busy1));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        breq = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int seq[6];
        int exp_seq[6];
        int n, hold, cnt;

        vt[0]  = '{2'b00, 2'b00, 1'b0, 1'b0};
        vt[1]  = '{2'b01, 2'b01, 1'b1, 1'b0};
        vt[2]  = '{2'b01, 2'b01, 1'b1, 1'b0};
        vt[3]  = '{2'b00, 2'b00, 1'b0, 1'b0};
        vt[4]  = '{2'b00, 2'b00, 1'b0, 1'b0};
        vt[5]  = '{2'b11, 2'b10, 1'b1, 1'b1};
        vt[6]  = '{2'b11, 2'b10, 1'b1, 1'b1};
        vt[7]  = '{2'b01, 2'b00, 1'b0, 1'b1};
        vt[8]  = '{2'b01, 2'b01, 1'b1, 1'b0};
        vt[9]  = '{2'b11, 2'b01, 1'b1, 1'b0};
        vt[10] = '{2'b10, 2'b00, 1'b0, 1'b0};
        vt[11] = '{2'b10, 2'b10, 1'b1, 1'b1};
        vt[12] = '{2'b00, 2'b00, 1'b0, 1'b1};
        vt[13] = '{2'b10, 2'b10, 1'b1, 1'b1};
        vt[14] = '{2'b00, 2'b00, 1'b0, 1'b1};
        vt[15] = '{2'b00, 2'b00, 1'b0, 1'b1};
        vt[16] = '{2'b00, 2'b00, 1'b0, 1'b1};
        vt[17] = '{2'b01, 2'b01, 1'b1, 1'b0};
        vt[18] = '{2'b00, 2'b00, 1'b0, 1'b0};
        vt[19] = '{2'b00, 2'b00, 1'b0, 1'b0};
        exp_seq = '{0, 1, 0, 1, 0, 1};

        rstn = 1'b0;
        breq = 2'b00;
        #12;
        chk("rst_bgrant", int'(g0), 0);
        chk("rst_bbusy",  int'(busy0), 0);
        chk("rst_msel",   int'(m0), 0);
        chk("rst_tevt",   int'(te0), 0);
        chk("rst_bgrant_wd", int'(g1), 0);
        chk("rst_tevt_wd",   int'(te1), 0);
        @(negedge clk);
        rstn = 1'b1;

        // cycle table: both instances must agree since no hold reaches 8 cycles
        for (int i = 0; i < 20; i++) begin
            breq = vt[i].breq;
            tick();
            chk($sformatf("vec%0d_bgrant", i), int'(g0), int'(vt[i].g));
            chk($sformatf("vec%0d_bbusy", i),  int'(busy0), int'(vt[i].busy));
            chk($sformatf("vec%0d_msel", i),   int'(m0), int'(vt[i].msel));
            chk($sformatf("vec%0d_tevt", i),   int'(te0), 0);
            chk($sformatf("vec%0d_bgrant_wd", i), int'(g1), int'(vt[i].g));
            chk($sformatf("vec%0d_tevt_wd", i),   int'(te1), 0);
        end

        // simultaneous requests after reset, each held 5 grant cycles
        do_reset();
        breq = 2'b11;
        tick();
        chk("sim_first", int'(g0), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sim_hold0", int'(g0), 1);
        end
        breq = 2'b10;
        tick();
        chk("sim_release", int'(g0), 0);
        tick();
        chk("sim_second", int'(g0), 2);
        chk("sim_second_msel", int'(m0), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sim_hold1", int'(g0), 2);
        end
        breq = 2'b00;
        tick();
        chk("sim_release1", int'(g0), 0);

        // fairness: both keep requesting, owner drops for one cycle to release
        do_reset();
        breq = 2'b11;
        n = 0;
        hold = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            tick();
            if (breq != 2'b11) begin
                breq = 2'b11;
            end else if (g0 != 2'b00) begin
                hold++;
                if (hold == 1) begin
                    seq[n] = int'(m0);
                    n++;
                end
                if (hold == 3) begin
                    breq = 2'b11 & ~g0;
                    hold = 0;
                end
            end
        end
        chk("fair_count", n, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("fair_grant%0d", i), seq[i], exp_seq[i]);

        // watchdog: master 1 never lets go
        do_reset();
        breq = 2'b10;
        tick();
        cnt = 0;
        while (g1 == 2'b10 && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("wd_hold_cycles", cnt, 8);
        chk("wd_tevt", int'(te1), 1);
        chk("wd_bgrant", int'(g1), 0);
        chk("nowd_still_granted", int'(g0), 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wd_masked", int'(g1), 0);
            chk("wd_tevt_pulse", int'(te1), 0);
        end
        breq = 2'b00;
        tick();
        chk("wd_unmask_idle", int'(g1), 0);
        breq = 2'b10;
        tick();
        chk("wd_regrant", int'(g1), 2);

        // asynchronous reset while master 1 owns the bus
        do_reset();
        breq = 2'b01;
        tick();
        breq = 2'b00;
        tick();
        tick();
        breq = 2'b10;
        tick();
        chk("arst_pre_grant", int'(g0), 2);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_bgrant", int'(g0), 0);
        chk("arst_bbusy",  int'(busy0), 0);
        chk("arst_msel",   int'(m0), 0);
        breq = 2'b11;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("arst_restart", int'(g0), 1);
        chk("arst_restart_msel", int'(m0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
